// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the 8-bit pipeline: opcodes, ALU encodings, shift FSM states.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int ISA_W = 8;

    // Four-bit major opcodes (IR[3:0])
    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_BPZ   = 4'b1101;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_NOP   = 4'b1010;

    // Three-bit minor opcodes (IR[2:0]); these take priority over the major table
    localparam logic [2:0] OP3_ORI   = 3'b111;
    localparam logic [2:0] OP3_SHIFT = 3'b011;

    // ALU operation select
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_NAND = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_PASS = 3'd7;

    typedef enum logic {
        SH_IDLE  = 1'b0,
        SH_SHIFT = 1'b1
    } shift_state_e;

    // One-hot instruction class; all zero means NOP (including unknown opcodes)
    typedef struct packed {
        logic load;
        logic store;
        logic add;
        logic sub;
        logic nand_op;
        logic ori;
        logic shift;
        logic bz;
        logic bnz;
        logic bpz;
        logic stop;
    } dec_t;

    function automatic dec_t decode(input logic [ISA_W-1:0] ir);
        dec_t d;
        d = '0;
        if (ir[2:0] == OP3_ORI) begin
            d.ori = 1'b1;
        end else if (ir[2:0] == OP3_SHIFT) begin
            d.shift = 1'b1;
        end else begin
            case (ir[3:0])
                OP_LOAD:  d.load    = 1'b1;
                OP_STORE: d.store   = 1'b1;
                OP_ADD:   d.add     = 1'b1;
                OP_SUB:   d.sub     = 1'b1;
                OP_NAND:  d.nand_op = 1'b1;
                OP_BZ:    d.bz      = 1'b1;
                OP_BNZ:   d.bnz     = 1'b1;
                OP_BPZ:   d.bpz     = 1'b1;
                OP_STOP:  d.stop    = 1'b1;
                default:  d = '0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/ex_shift_seq.sv
// Multi-cycle shift sequencer: one shifter step per cycle for IR[5:4] cycles.
// Latency: shift_en is combinational from the EX slot; counter/state registered.
// Backpressure: shift_stall holds the EX slot for all but the last shift cycle.
module ex_shift_seq
    import cpu_pkg::*;
#(
    parameter int SHAMT_W = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_vld,
    input  logic [SHAMT_W-1:0] amount,
    output logic               shift_en,
    output logic               shift_stall
);

    localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);

    shift_state_e       state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    // State and remaining-step counter; reset aborts any shift in progress
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= SH_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // First shift cycle is taken in IDLE; SHIFT counts down the remaining steps
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_en    = 1'b0;
        shift_stall = 1'b0;
        case (state_q)
            SH_IDLE: begin
                if (start_vld && amount != '0) begin
                    shift_en = 1'b1;
                    if (amount > ONE) begin
                        shift_stall = 1'b1;
                        state_d     = SH_SHIFT;
                        cnt_d       = amount - ONE;
                    end
                end
            end
            SH_SHIFT: begin
                shift_en    = 1'b1;
                shift_stall = (cnt_q > ONE);
                cnt_d       = cnt_q - ONE;
                if (cnt_q <= ONE) begin
                    state_d = SH_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SH_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/ex_wb_control.sv
// EX/WB stage control: decodes the EX slot, resolves branches, sequences shifts, issues RF write-back.
// Latency: EX controls in the cycle after accept, WB (ir4_out/rf_write/rf_wsel) one cycle later.
// Backpressure: stall during multi-cycle shifts and STOP/halt; flush on a taken branch drops ir3_in.
// Optional: define EX_FORWARD_EN to add the fwd_a/fwd_b forwarding hints.
module ex_wb_control
    import cpu_pkg::*;
#(
    parameter int IR_W    = ISA_W,
    parameter int SHAMT_W = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IR_W-1:0] ir3_in,
    input  logic            ir3_valid,
    input  logic            flag_z,
    input  logic            flag_n,
    output logic [2:0]      alu_op,
    output logic            alu_src_imm,
    output logic            shift_en,
    output logic            shift_dir,
    output logic            mem_read,
    output logic            mem_write,
    output logic            flag_write,
    output logic            stall,
    output logic            flush,
    output logic            branch_taken,
    output logic [IR_W-1:0] ir4_out,
    output logic            rf_write,
    output logic [1:0]      rf_wsel,
    output logic            halted
`ifdef EX_FORWARD_EN
    ,
    output logic            fwd_a,
    output logic            fwd_b
`endif
);

    logic            ex_vld_q;
    logic [IR_W-1:0] ex_ir_q;
    logic [IR_W-1:0] wb_ir_q;
    logic            wb_we_q;
    logic [1:0]      wb_sel_q;
    logic            halted_q;

    dec_t ex_dec;
    logic shift_stall;
    logic accept;
    logic ex_done;
    logic ex_writes;

    // Decode of the occupied EX slot; an empty slot decodes to all-zero controls
    always_comb begin
        ex_dec = '0;
        if (ex_vld_q) begin
            ex_dec = decode(ex_ir_q);
        end
    end

    ex_shift_seq #(
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clock       (clock),
        .reset       (reset),
        .start_vld   (ex_dec.shift),
        .amount      (ex_ir_q[4 +: SHAMT_W]),
        .shift_en    (shift_en),
        .shift_stall (shift_stall)
    );

    // ALU select: bubbles drive 0, non-ALU instructions pass operand through
    always_comb begin
        alu_op = ALU_ADD;
        if (ex_vld_q) begin
            if (ex_dec.add)          alu_op = ALU_ADD;
            else if (ex_dec.sub)     alu_op = ALU_SUB;
            else if (ex_dec.nand_op) alu_op = ALU_NAND;
            else if (ex_dec.ori)     alu_op = ALU_OR;
            else                     alu_op = ALU_PASS;
        end
    end

    assign alu_src_imm  = ex_dec.ori;
    assign shift_dir    = ex_dec.shift & ex_ir_q[3];
    assign mem_read     = ex_dec.load;
    assign mem_write    = ex_dec.store;
    // Shifts update flags on every step so Z/N track the partially shifted value
    assign flag_write   = ex_dec.add | ex_dec.sub | ex_dec.nand_op | ex_dec.ori | ex_dec.shift;
    assign branch_taken = (ex_dec.bz & flag_z) | (ex_dec.bnz & ~flag_z) | (ex_dec.bpz & ~flag_n);
    assign flush        = branch_taken;
    assign stall        = shift_stall | ex_dec.stop | halted_q;

    assign accept    = ir3_valid & ~stall & ~flush & ~halted_q;
    assign ex_done   = ex_vld_q & ~shift_stall;
    assign ex_writes = ex_dec.load | ex_dec.add | ex_dec.sub | ex_dec.nand_op
                     | ex_dec.ori | ex_dec.shift;

    // EX slot: held while a shift is still stepping, otherwise refilled or emptied
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_vld_q <= 1'b0;
            ex_ir_q  <= '0;
        end else if (!shift_stall) begin
            ex_vld_q <= accept;
            if (accept) begin
                ex_ir_q <= ir3_in;
            end
        end
    end

    // WB slot: one-cycle image of the instruction that just left EX
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_ir_q  <= '0;
            wb_we_q  <= 1'b0;
            wb_sel_q <= 2'd0;
        end else begin
            wb_ir_q  <= ex_done ? ex_ir_q : '0;
            wb_we_q  <= ex_done & ex_writes;
            wb_sel_q <= (ex_done & ex_writes) ? (ex_dec.ori ? 2'd1 : ex_ir_q[IR_W-1 -: 2]) : 2'd0;
        end
    end

    // Sticky halt once STOP has passed through EX
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halted_q <= 1'b0;
        end else if (ex_dec.stop) begin
            halted_q <= 1'b1;
        end
    end

    assign ir4_out = wb_ir_q;
    assign rf_write = wb_we_q;
    assign rf_wsel  = wb_sel_q;
    assign halted   = halted_q;

`ifdef EX_FORWARD_EN
    // Forward when the register an EX operand reads is being written back this cycle
    assign fwd_a = (ex_dec.add | ex_dec.sub | ex_dec.nand_op | ex_dec.store | ex_dec.shift)
                 & wb_we_q & (wb_sel_q == ex_ir_q[7:6]);
    assign fwd_b = (ex_dec.add | ex_dec.sub | ex_dec.nand_op)
                 & wb_we_q & (wb_sel_q == ex_ir_q[5:4]);
`else
    // No forwarding paths: upstream inserts bubbles to cover read-after-write hazards.
`endif

endmodule
